// File: rtl/operand_fetch_stage.sv
// D-stage operand fetch: GRF read addressing, E/M forwarding, Tuse/Tnew hazard
// detection and the D/E pipeline register, which takes a bubble on stall or reset.
module operand_fetch_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int T_W    = 2
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              D_valid,
   input  logic [DATA_W-1:0] D_pc,
   input  logic [ADDR_W-1:0] D_rs,
   input  logic [ADDR_W-1:0] D_rt,
   input  logic [T_W-1:0]    D_rs_tuse,
   input  logic [T_W-1:0]    D_rt_tuse,
   input  logic [ADDR_W-1:0] D_wa,
   input  logic [T_W-1:0]    D_tnew,
   output logic [ADDR_W-1:0] grf_a1,
   output logic [ADDR_W-1:0] grf_a2,
   input  logic [DATA_W-1:0] grf_rd1,
   input  logic [DATA_W-1:0] grf_rd2,
   input  logic [ADDR_W-1:0] E_fw_wa,
   input  logic [T_W-1:0]    E_fw_tnew,
   input  logic [DATA_W-1:0] E_fw_wd,
   input  logic [ADDR_W-1:0] M_fw_wa,
   input  logic [T_W-1:0]    M_fw_tnew,
   input  logic [DATA_W-1:0] M_fw_wd,
   output logic [DATA_W-1:0] D_rs_val,
   output logic [DATA_W-1:0] D_rt_val,
   output logic              stall,
   output logic              E_valid,
   output logic [DATA_W-1:0] E_pc,
   output logic [ADDR_W-1:0] E_rs,
   output logic [ADDR_W-1:0] E_rt,
   output logic [DATA_W-1:0] E_rs_val,
   output logic [DATA_W-1:0] E_rt_val,
   output logic [ADDR_W-1:0] E_wa,
   output logic [T_W-1:0]    E_tnew
);

   // Pipeline control: stall freezes PC and F/D upstream while this stage
   // sends a bubble into E; there is no valid/ready pair, D_valid simply
   // qualifies the D inputs and E_valid qualifies the D/E register.

   logic rs_match_e, rs_match_m, rt_match_e, rt_match_m;
   logic rs_hazard, rt_hazard;
   logic load;

   assign grf_a1 = D_rs;
   assign grf_a2 = D_rt;

   // Register 0 never matches, so a stage with wa==0 is treated as non-writing.
   assign rs_match_e = (D_rs != '0) && (D_rs == E_fw_wa);
   assign rs_match_m = (D_rs != '0) && (D_rs == M_fw_wa);
   assign rt_match_e = (D_rt != '0) && (D_rt == E_fw_wa);
   assign rt_match_m = (D_rt != '0) && (D_rt == M_fw_wa);

   always_comb begin
      D_rs_val = grf_rd1;
      if (D_rs == '0)
         D_rs_val = '0;
      else if (rs_match_e && (E_fw_tnew == '0))
         D_rs_val = E_fw_wd;
      else if (rs_match_m && (M_fw_tnew == '0))
         D_rs_val = M_fw_wd;
   end

   always_comb begin
      D_rt_val = grf_rd2;
      if (D_rt == '0)
         D_rt_val = '0;
      else if (rt_match_e && (E_fw_tnew == '0))
         D_rt_val = E_fw_wd;
      else if (rt_match_m && (M_fw_tnew == '0))
         D_rt_val = M_fw_wd;
   end

   // Tnew never exceeds 3, so a tuse of 3 (unused source) can never stall.
   assign rs_hazard = (rs_match_e && (E_fw_tnew > D_rs_tuse)) ||
                      (rs_match_m && (M_fw_tnew > D_rs_tuse));
   assign rt_hazard = (rt_match_e && (E_fw_tnew > D_rt_tuse)) ||
                      (rt_match_m && (M_fw_tnew > D_rt_tuse));

   assign stall = D_valid && (rs_hazard || rt_hazard);
   assign load  = D_valid && !stall;

   always_ff @(posedge clk) begin
      if (Reset || !load) begin
         E_valid  <= 1'b0;
         E_pc     <= '0;
         E_rs     <= '0;
         E_rt     <= '0;
         E_rs_val <= '0;
         E_rt_val <= '0;
         E_wa     <= '0;
         E_tnew   <= '0;
      end else begin
         E_valid  <= 1'b1;
         E_pc     <= D_pc;
         E_rs     <= D_rs;
         E_rt     <= D_rt;
         E_rs_val <= D_rs_val;
         E_rt_val <= D_rt_val;
         E_wa     <= D_wa;
         E_tnew   <= D_tnew;
      end
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: table of D-stage vectors with
// hand-computed forwarded values and stall, plus reset sequences.
module tb_operand_fetch_stage;

   logic        clk;
   logic        Reset;
   logic        D_valid;
   logic [31:0] D_pc;
   logic [4:0]  D_rs, D_rt, D_wa;
   logic [1:0]  D_rs_tuse, D_rt_tuse, D_tnew;
   logic [4:0]  grf_a1, grf_a2;
   logic [31:0] grf_rd1, grf_rd2;
   logic [4:0]  E_fw_wa, M_fw_wa;
   logic [1:0]  E_fw_tnew, M_fw_tnew;
   logic [31:0] E_fw_wd, M_fw_wd;
   logic [31:0] D_rs_val, D_rt_val;
   logic        stall;
   logic        E_valid;
   logic [31:0] E_pc, E_rs_val, E_rt_val;
   logic [4:0]  E_rs, E_rt, E_wa;
   logic [1:0]  E_tnew;

   int checks = 0;
   int errors = 0;

   operand_fetch_stage dut (
      .clk(clk), .Reset(Reset), .D_valid(D_valid), .D_pc(D_pc),
      .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
      .D_wa(D_wa), .D_tnew(D_tnew), .grf_a1(grf_a1), .grf_a2(grf_a2),
      .grf_rd1(grf_rd1), .grf_rd2(grf_rd2),
      .E_fw_wa(E_fw_wa), .E_fw_tnew(E_fw_tnew), .E_fw_wd(E_fw_wd),
      .M_fw_wa(M_fw_wa), .M_fw_tnew(M_fw_tnew), .M_fw_wd(M_fw_wd),
      .D_rs_val(D_rs_val), .D_rt_val(D_rt_val), .stall(stall),
      .E_valid(E_valid), .E_pc(E_pc), .E_rs(E_rs), .E_rt(E_rt),
      .E_rs_val(E_rs_val), .E_rt_val(E_rt_val), .E_wa(E_wa), .E_tnew(E_tnew)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs, rt;
      logic [1:0]  rs_tuse, rt_tuse;
      logic [4:0]  wa;
      logic [1:0]  tnew;
      logic [31:0] rd1, rd2;
      logic [4:0]  e_wa;
      logic [1:0]  e_tnew;
      logic [31:0] e_wd;
      logic [4:0]  m_wa;
      logic [1:0]  m_tnew;
      logic [31:0] m_wd;
      logic [31:0] exp_rs_val, exp_rt_val;
      logic        exp_stall;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      D_valid = v.valid; D_pc = v.pc; D_rs = v.rs; D_rt = v.rt;
      D_rs_tuse = v.rs_tuse; D_rt_tuse = v.rt_tuse; D_wa = v.wa; D_tnew = v.tnew;
      grf_rd1 = v.rd1; grf_rd2 = v.rd2;
      E_fw_wa = v.e_wa; E_fw_tnew = v.e_tnew; E_fw_wd = v.e_wd;
      M_fw_wa = v.m_wa; M_fw_tnew = v.m_tnew; M_fw_wd = v.m_wd;
   endtask

   task automatic check_e_zero(input string tag);
      chk({tag, " E_valid"},  32'(E_valid), 32'd0);
      chk({tag, " E_pc"},     E_pc, 32'd0);
      chk({tag, " E_rs"},     32'(E_rs), 32'd0);
      chk({tag, " E_rt"},     32'(E_rt), 32'd0);
      chk({tag, " E_rs_val"}, E_rs_val, 32'd0);
      chk({tag, " E_rt_val"}, E_rt_val, 32'd0);
      chk({tag, " E_wa"},     32'(E_wa), 32'd0);
      chk({tag, " E_tnew"},   32'(E_tnew), 32'd0);
   endtask

   function automatic vec_t mk(input logic valid, input logic [31:0] pc,
         input logic [4:0] rs, input logic [1:0] rs_tuse, input logic [4:0] rt,
         input logic [1:0] rt_tuse, input logic [31:0] rd1, input logic [31:0] rd2,
         input logic [4:0] e_wa, input logic [1:0] e_tnew, input logic [31:0] e_wd,
         input logic [4:0] m_wa, input logic [1:0] m_tnew, input logic [31:0] m_wd,
         input logic [31:0] xrs, input logic [31:0] xrt, input logic xstall);
      vec_t v;
      v.valid = valid; v.pc = pc; v.rs = rs; v.rs_tuse = rs_tuse;
      v.rt = rt; v.rt_tuse = rt_tuse; v.rd1 = rd1; v.rd2 = rd2;
      v.wa = 5'(pc[6:2]); v.tnew = 2'(pc[3:2]);
      v.e_wa = e_wa; v.e_tnew = e_tnew; v.e_wd = e_wd;
      v.m_wa = m_wa; v.m_tnew = m_tnew; v.m_wd = m_wd;
      v.exp_rs_val = xrs; v.exp_rt_val = xrt; v.exp_stall = xstall;
      return v;
   endfunction

   initial begin
      vec_t v;
      logic [31:0] x_pc, x_rsv, x_rtv;
      logic        x_valid;
      logic [4:0]  x_rs, x_rt, x_wa;
      logic [1:0]  x_tnew;

      //        vld pc           rs tu rt tu rd1          rd2          e_wa tn e_wd      m_wa tn m_wd         exp_rs       exp_rt       stl
      vecs.push_back(mk(1, 32'h3004, 5, 1, 6, 1, 32'h11,       32'h66,      5, 0, 32'hAA,   5, 0, 32'hBB,     32'hAA,      32'h66,      0)); // E over M
      vecs.push_back(mk(1, 32'h3008, 1, 3, 8, 1, 32'h101,      32'h202,     8, 2, 32'h0,    0, 0, 32'h0,      32'h101,     32'h202,     1)); // load-use
      vecs.push_back(mk(1, 32'h3008, 1, 3, 8, 1, 32'h101,      32'h202,     8, 0, 32'h55,   0, 0, 32'h0,      32'h101,     32'h55,      0)); // resolved
      vecs.push_back(mk(1, 32'h300C, 0, 0, 0, 0, 32'hDEAD,     32'hBEEF,    0, 0, 32'h1,    0, 0, 32'h2,      32'h0,       32'h0,       0)); // reg 0
      vecs.push_back(mk(1, 32'h3010, 3, 0, 4, 3, 32'h33,       32'h44,      0, 0, 32'h0,    3, 1, 32'h0,      32'h33,      32'h44,      1)); // branch stall
      vecs.push_back(mk(1, 32'h3010, 3, 0, 4, 3, 32'h33,       32'h44,      0, 0, 32'h0,    3, 0, 32'h7,      32'h7,       32'h44,      0)); // M fwd
      vecs.push_back(mk(1, 32'h3014, 9, 3, 2, 1, 32'h99,       32'h22,      9, 2, 32'hF0,   0, 0, 32'h0,      32'h99,      32'h22,      0)); // tuse=3
      vecs.push_back(mk(1, 32'h3018, 10, 0, 2, 0, 32'hA0,      32'h20,     11, 2, 32'hF1,   0, 0, 32'h0,      32'hA0,      32'h20,      0)); // no match
      vecs.push_back(mk(0, 32'h301C, 8, 0, 0, 0, 32'h80,       32'h0,       8, 3, 32'h0,    0, 0, 32'h0,      32'h80,      32'h0,       0)); // invalid
      vecs.push_back(mk(1, 32'h3020, 13, 1, 12, 2, 32'hD0,     32'hC0,     13, 1, 32'hE0,  12, 0, 32'hC0FFEE, 32'hD0,      32'hC0FFEE,  0)); // tnew==tuse
      vecs.push_back(mk(1, 32'h3024, 7, 2, 0, 0, 32'h70,       32'h0,       7, 3, 32'h0,    0, 0, 32'h0,      32'h70,      32'h0,       1)); // E tnew 3
      vecs.push_back(mk(1, 32'h3028, 0, 0, 14, 1, 32'h0,       32'hE4,      0, 0, 32'h0,   14, 2, 32'h0,      32'h0,       32'hE4,      1)); // M tnew 2

      // Reset held two cycles with a valid instruction at 0x3000.
      v = mk(1, 32'h3000, 0, 3, 0, 3, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      drive(v);
      Reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_e_zero("reset");
      @(negedge clk) Reset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset E_valid", 32'(E_valid), 32'd1);
      chk("post_reset E_pc", E_pc, 32'h3000);

      foreach (vecs[i]) begin
         v = vecs[i];
         @(negedge clk);
         drive(v);
         #1;
         chk($sformatf("v%0d grf_a1", i), 32'(grf_a1), 32'(v.rs));
         chk($sformatf("v%0d grf_a2", i), 32'(grf_a2), 32'(v.rt));
         chk($sformatf("v%0d D_rs_val", i), D_rs_val, v.exp_rs_val);
         chk($sformatf("v%0d D_rt_val", i), D_rt_val, v.exp_rt_val);
         chk($sformatf("v%0d stall", i), 32'(stall), 32'(v.exp_stall));
         x_valid = v.valid && !v.exp_stall;
         x_pc  = x_valid ? v.pc : 32'h0;
         x_rs  = x_valid ? v.rs : 5'h0;
         x_rt  = x_valid ? v.rt : 5'h0;
         x_rsv = x_valid ? v.exp_rs_val : 32'h0;
         x_rtv = x_valid ? v.exp_rt_val : 32'h0;
         x_wa  = x_valid ? v.wa : 5'h0;
         x_tnew = x_valid ? v.tnew : 2'h0;
         @(posedge clk); #1;
         chk($sformatf("v%0d E_valid", i), 32'(E_valid), 32'(x_valid));
         chk($sformatf("v%0d E_pc", i), E_pc, x_pc);
         chk($sformatf("v%0d E_rs", i), 32'(E_rs), 32'(x_rs));
         chk($sformatf("v%0d E_rt", i), 32'(E_rt), 32'(x_rt));
         chk($sformatf("v%0d E_rs_val", i), E_rs_val, x_rsv);
         chk($sformatf("v%0d E_rt_val", i), E_rt_val, x_rtv);
         chk($sformatf("v%0d E_wa", i), 32'(E_wa), 32'(x_wa));
         chk($sformatf("v%0d E_tnew", i), 32'(E_tnew), 32'(x_tnew));
      end

      // Stall held for two cycles, then Reset asserted during the stall.
      @(negedge clk);
      drive(vecs[1]);
      repeat (2) @(posedge clk);
      #1;
      chk("hold stall", 32'(stall), 32'd1);
      chk("hold E_valid", 32'(E_valid), 32'd0);
      @(negedge clk) Reset = 1'b1;
      @(posedge clk); #1;
      check_e_zero("reset_in_stall");
      @(negedge clk);
      Reset = 1'b0;
      drive(vecs[2]);
      @(posedge clk); #1;
      chk("resume E_valid", 32'(E_valid), 32'd1);
      chk("resume E_pc", E_pc, 32'h3008);
      chk("resume E_rt_val", E_rt_val, 32'h55);

      // Valid instruction directly after a bubble, Reset asserted while no hazard.
      @(negedge clk);
      drive(vecs[0]);
      Reset = 1'b1;
      @(posedge clk); #1;
      chk("reset_wins E_valid", 32'(E_valid), 32'd0);
      @(negedge clk) Reset = 1'b0;
      @(posedge clk); #1;
      chk("after E_rs_val", E_rs_val, 32'hAA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Reader side of the 32x32 general register file in the 5-stage pipeline; sits in the D stage.
- Drives the GRF read addresses and takes the combinational RD1/RD2 data.
- Applies E/M-stage forwarding and detects Tuse/Tnew hazards, raising a stall when needed.
- Holds the D/E pipeline register. On a stall it inserts a bubble into E.

Parameters:
- DATA_W, 32, operand/data width.
- ADDR_W, 5, register address width.
- T_W, 2, width of Tuse/Tnew fields.

Ports:
- clk  in  1  pipeline clock; D/E register updates on posedge.
- Reset  in  1  synchronous, active-high.
- D_valid  in  1  D-stage instruction valid.
- D_pc  in  DATA_W  D-stage PC.
- D_rs  in  ADDR_W  source 1 register.
- D_rt  in  ADDR_W  source 2 register.
- D_rs_tuse  in  T_W  stages until rs is consumed: 0=D, 1=E, 2=M, 3=unused.
- D_rt_tuse  in  T_W  same encoding, for rt.
- D_wa  in  ADDR_W  destination register of the D instruction.
- D_tnew  in  T_W  cycles from E entry until the result exists.
- grf_a1  out  ADDR_W  GRF read address 1, equal to D_rs.
- grf_a2  out  ADDR_W  GRF read address 2, equal to D_rt.
- grf_rd1  in  DATA_W  GRF read data 1.
- grf_rd2  in  DATA_W  GRF read data 2.
- E_fw_wa  in  ADDR_W  E-stage destination register.
- E_fw_tnew  in  T_W  E-stage remaining Tnew.
- E_fw_wd  in  DATA_W  E-stage result; meaningful only when E_fw_tnew==0.
- M_fw_wa  in  ADDR_W  M-stage destination register.
- M_fw_tnew  in  T_W  M-stage remaining Tnew.
- M_fw_wd  in  DATA_W  M-stage result.
- D_rs_val  out  DATA_W  forwarded rs value, for D-stage branch compare.
- D_rt_val  out  DATA_W  forwarded rt value.
- stall  out  1  freeze PC and F/D.
- E_valid  out  1  D/E register valid.
- E_pc  out  DATA_W  D/E register PC.
- E_rs  out  ADDR_W  D/E register rs address.
- E_rt  out  ADDR_W  D/E register rt address.
- E_rs_val  out  DATA_W  D/E register rs value.
- E_rt_val  out  DATA_W  D/E register rt value.
- E_wa  out  ADDR_W  D/E register destination.
- E_tnew  out  T_W  D/E register Tnew.

Behaviour:
- grf_a1 = D_rs and grf_a2 = D_rt, combinational.
- W-stage forwarding is not done here. The GRF writes on negedge, so grf_rd reflects a W write before the next posedge.
- Match rule: a source reg r matches stage X when r != 0 and r == X_fw_wa.
  - X_fw_wa == 0 means the stage does not write.
- Forward select per source, with E having priority over M:
  - if E matches and E_fw_tnew==0, use E_fw_wd;
  - else if M matches and M_fw_tnew==0, use M_fw_wd;
  - else use grf_rd.
  - Reg 0 always yields 0, regardless of GRF contents.
- Hazard per source:
  - stall if the source matches E and E_fw_tnew > tuse;
  - stall if the source matches M and M_fw_tnew > tuse.
  - tuse=3 never stalls.
  - stall = D_valid & (rs_hazard | rt_hazard).
- If a source matches E but is not forwarded and no stall occurs, the stale grf value is captured. Downstream forwarding in E/M resolves it, which is why E_rs/E_rt are carried.
- D/E register update on posedge:
  - Reset, or stall, or !D_valid: bubble. E_valid=0 and all other E_* outputs = 0.
  - Otherwise: load D_pc, D_rs, D_rt, the forwarded values, D_wa, and D_tnew.
- Reset values: every E_* output is 0. stall and D_* values are combinational, with no reset state.
- Reset asserted mid-stall: the bubble wins, and the pipeline resumes the cycle after Reset deasserts.
- A stall holds for as long as the hazard persists. The D inputs are held stable by the freeze, so the result is deterministic.
- Latency: one cycle from D to E outputs.
- No combinational path from the E_* outputs back to stall.

Test Plan:
- Reset held 2 cycles while D_valid=1 and D_pc=0x3000 -> all E_* outputs=0, E_valid=0. The cycle after release -> E_pc=0x3000, E_valid=1.
- GRF $5=0x11, E_fw_wa=5, E_fw_tnew=0, E_fw_wd=0xAA, M_fw_wa=5, M_fw_tnew=0, M_fw_wd=0xBB, D_rs=5 -> D_rs_val=0xAA (E priority), stall=0.
- Load in E: E_fw_wa=8, E_fw_tnew=2; D_rt=8, D_rt_tuse=1 -> stall=1 and a bubble in E. Next cycle, with E_fw_tnew=0 and value 0x55 -> stall=0, E_rt_val=0x55.
- D_rs=0 with grf_rd1=0xDEAD and E_fw_wa=0, E_fw_tnew=0, E_fw_wd=0x1 -> D_rs_val=0, stall=0.
- Branch source: D_rs_tuse=0, M_fw_wa=3, M_fw_tnew=1, D_rs=3 -> stall=1. Once M_fw_tnew=0 and M_fw_wd=0x7 -> D_rs_val=0x7, stall=0.
- Tuse=3, or no address match, with E_fw_tnew=2 -> stall=0. The instruction enters E the next cycle with the grf values.
